// File: rtl/scan_loader.sv
// scan_loader: host-side serial loader for the pattern buffer array.
//
// Accepts a load or readback request for one of no_bufs pattern buffers and
// moves buffer_size bytes through that buffer's scan chain, MSB first, byte 0
// first. Readback recirculates the chain (sin = sout) so contents survive.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   req_valid/ready  - request handshake; req_rd selects readback, req_addr
//                      selects the buffer
//   wr_data/valid/ready - host load byte stream
//   rd_data/valid/ready - host readback byte stream
//   busy, done       - status; done pulses one cycle at end of a request
//   sin, ssel, saddr - scan drive to the buffer array
//   sout             - scan data returned from the selected buffer
module scan_loader #(
  parameter int unsigned buffer_size  = 22,
  parameter int unsigned buffer_width = 8,
  parameter int unsigned no_bufs      = 8,
  localparam int unsigned AW = (no_bufs > 1) ? $clog2(no_bufs) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rd,
  input  logic [AW-1:0]           req_addr,
  input  logic [buffer_width-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [buffer_width-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    sin,
  output logic                    ssel,
  output logic [AW-1:0]           saddr,
  input  logic                    sout
);

  localparam int unsigned BCW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
  localparam int unsigned BTW = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(buffer_size - 1);
  localparam logic [BTW-1:0] LAST_BIT  = BTW'(buffer_width - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e                  state_q,     state_d;
  logic                    mode_q,      mode_d;
  logic [AW-1:0]           saddr_q,     saddr_d;
  logic [BCW-1:0]          byte_cnt_q,  byte_cnt_d;
  logic [BTW-1:0]          bit_cnt_q,   bit_cnt_d;
  logic [buffer_width-1:0] shreg_q,     shreg_d;
  logic                    req_ready_q, req_ready_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;
  logic                    ssel_q,      ssel_d;
  logic                    wr_ready_q,  wr_ready_d;
  logic                    rd_valid_q,  rd_valid_d;
  logic [buffer_width-1:0] rd_data_q,   rd_data_d;

  logic last_byte;
  logic last_bit;

  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign last_bit  = (bit_cnt_q == LAST_BIT);

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    saddr_d    = saddr_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d     = req_rd;
          saddr_d    = req_addr;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = req_rd ? S_SHIFT : S_FETCH;
        end
      end

      S_FETCH: begin
        if (wr_valid) begin
          shreg_d   = wr_data;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // Readback captures the chain output; load just drains shreg.
        shreg_d   = {shreg_q[buffer_width-2:0], (mode_q ? sout : 1'b0)};
        bit_cnt_d = bit_cnt_q + BTW'(1);
        if (last_bit) begin
          bit_cnt_d = '0;
          if (mode_q) begin
            state_d = S_PRESENT;
          end else if (last_byte) begin
            state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            // Back-to-back bytes continue shifting without a bubble.
            if (wr_valid) begin
              shreg_d = wr_data;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
      end

      S_PRESENT: begin
        if (rd_ready) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            state_d    = S_SHIFT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    ssel_d      = (state_d == S_SHIFT);
    rd_valid_d  = (state_d == S_PRESENT);
    // A load byte is requested in FETCH and on the final bit of a non-last byte.
    wr_ready_d  = (state_d == S_FETCH) ||
                  ((state_d == S_SHIFT) && !mode_d &&
                   (bit_cnt_d == LAST_BIT) && (byte_cnt_d != LAST_BYTE));
    rd_data_d   = (state_d == S_PRESENT) ? shreg_d : rd_data_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      saddr_q     <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ssel_q      <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      saddr_q     <= saddr_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ssel_q      <= ssel_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Recirculation must present sout on sin in the same cycle, so sin is a
  // combinational path from sout during readback; it is forced low when idle.
  assign sin = ssel_q & (mode_q ? sout : shreg_q[buffer_width-1]);

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ssel      = ssel_q;
  assign saddr     = saddr_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: doc/scan_loader.md
# scan_loader

Host-side serial loader that sits directly upstream of the pattern buffer array and drives its scan interface (`sin`, `ssel`, `saddr`, `sout`). It accepts a load or readback request for one of the 8 pattern buffers. It then streams `buffer_size` bytes into that buffer's scan chain, MSB first, or shifts the chain out for readback while recirculating it so contents are preserved. It gives the host a byte-wide valid/ready interface, so software never bit-bangs the chain.

## Interface

Parameters:
- `buffer_size`, 22: bytes per pattern buffer; chain length N = `buffer_size`*`buffer_width`.
- `buffer_width`, 8: bits per byte; also the host data width.
- `no_bufs`, 8: number of buffers; `saddr` is 3 bits.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: high only in IDLE.
- `req_rd` in 1: 0 = load, 1 = readback.
- `req_addr` in 3: target buffer index.
- `wr_data` in `buffer_width`: load byte.
- `wr_valid` in 1: load byte handshake.
- `wr_ready` out 1: load byte handshake.
- `rd_data` out `buffer_width`: readback byte.
- `rd_valid` out 1: readback byte handshake.
- `rd_ready` in 1: readback byte handshake.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at end of request.
- `sin` out 1: scan data to buffer array.
- `ssel` out 1: scan shift enable; the selected buffer shifts one bit per cycle while high.
- `saddr` out 3: buffer select, registered.
- `sout` in 1: scan data from selected buffer; combinational, sampled on the same edge as the shift.

## Operation

- States: IDLE, FETCH, SHIFT, PRESENT, DONE.
  - IDLE: `req_ready`=1.
  - On `req_valid`: latch `req_rd` into `mode` and `req_addr` into `saddr`; clear `byte_cnt` and `bit_cnt`.
  - Next state: load goes to FETCH; readback goes to SHIFT.
  - `req_valid` in any other state is ignored.
- FETCH (load only): `wr_ready`=1; on `wr_valid`, load `wr_data` into `shreg`, then go to SHIFT.
- SHIFT:
  - `ssel`=1 for 8 consecutive cycles; `bit_cnt` counts 0..7.
  - Load: `sin`=`shreg`[7]; `shreg` shifts left.
  - Readback: `sin`=`sout`; `shreg` <= {`shreg`[6:0],`sout`}.
- Load, on the cycle with `bit_cnt`==7:
  - Last byte: go to DONE.
  - Otherwise `wr_ready`=1 in that same cycle.
  - If `wr_valid`, reload `shreg`, clear `bit_cnt`, stay in SHIFT (no bubble); else go to FETCH.
  - `byte_cnt` increments at every byte boundary.
- Readback, after `bit_cnt`==7: go to PRESENT.
- PRESENT: `rd_valid`=1, `rd_data`=`shreg`, `ssel`=0.
  - On `rd_ready`: last byte goes to DONE, otherwise to SHIFT.
- DONE: `done`=1 for one cycle, then IDLE.
- Bit order:
  - Byte 0 is sent first, each byte MSB first.
  - After a full load, readback returns byte 0 first with identical values.
  - Readback shifts exactly N bits with recirculation, so the chain ends in its original state.
- `ssel` is low in every state except SHIFT, so stalls on `wr_valid`/`rd_ready` freeze the chain.
- `saddr` is stable for the whole request and changes only on request accept.

## Timing

- Reset values: state IDLE. `req_ready`=1; `busy`, `done`, `ssel`, `sin`, `wr_ready`, `rd_valid`=0. `rd_data`=0, `saddr`=0.
- `rst` mid-request: takes effect the next edge regardless of state; `ssel` is 0 from the following cycle. The partially shifted buffer is left as is; no recovery is attempted.
- Load latency with `wr_valid` held high:
  - 1 accept cycle + 1 FETCH + N SHIFT cycles + 1 DONE.
  - 22 bytes gives 176 `ssel` cycles and `done` at cycle 178 after accept.
- Readback latency with `rd_ready` held high:
  - 9 cycles per byte (8 SHIFT + 1 PRESENT).
  - `rd_valid` first asserts 9 cycles after accept.
- `byte_cnt` width = ceil(log2(`buffer_size`)); compare against `buffer_size`-1 for last byte. No wrap beyond it.

## Test plan

- Load buffer 3 with bytes 0x00..0x15, `wr_valid` held high -> exactly 176 `ssel` cycles with `saddr`=3 throughout, `done` pulses once. A readback of buffer 3 then returns 0x00..0x15 in order.
- Two consecutive readbacks of buffer 3 -> both return 0x00..0x15. Buffers 0-2 and 4-7 are unchanged (the bench uses eight 176-bit shift models).
- Drop `wr_valid` for 5 cycles after byte 7 -> `ssel`=0 for those cycles plus the FETCH cycle. Subsequent readback data is unchanged.
- Readback with `rd_ready` low for 4 cycles on byte 10 -> `rd_valid` and `rd_data` are held stable and `ssel`=0 while stalled. All 22 bytes are correct.
- Assert `rst` during load byte 10 -> next cycle `ssel`=0, `busy`=0, `req_ready`=1, no `done`. A new load then completes normally.
- `req_valid` pulsed while `busy` -> no effect on state, `saddr`, or transfer count.
